// File: rtl/reflet_float_add_reg.sv
// reflet_float_add_reg: binary32 adder with a registered result, one cycle latency.
// Ports: clk, reset (sync, active-low), in_valid, in1, in2, enable_add, enable_sub -> sum, out_valid.
module reflet_float_add_reg (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [31:0] in1,
   input  logic [31:0] in2,
   input  logic        enable_add,
   input  logic        enable_sub,
   output logic [31:0] sum,
   output logic        out_valid
);

   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   logic [31:0] sum_d, sum_q;
   logic        out_valid_d, out_valid_q;
   logic [31:0] result;

   logic        s1, s2;
   logic [7:0]  e1, e2;
   logic [22:0] f1, f2;
   logic        nan1, nan2, inf1, inf2, zero1, zero2;

   logic        swap, eff_sub, sa;
   logic [7:0]  ea, eb, diff;
   logic [23:0] ma, mb;
   logic [26:0] b_ext, b_shift, b_mask;
   logic        b_lost;
   logic [27:0] add_s;
   logic [26:0] sub_s, sub_n;
   logic [4:0]  lz;
   logic signed [9:0] exp_r;
   logic [22:0] mant_r;

   function automatic logic [4:0] lzc27(input logic [26:0] v);
      logic [4:0] n;
      n = 5'd27;
      for (int i = 0; i < 27; i++) begin
         if (v[i]) n = 5'(26 - i);
      end
      return n;
   endfunction

   always_comb begin
      {s1, e1, f1} = in1;
      {s2, e2, f2} = in2;
      nan1  = (e1 == 8'hFF) && (f1 != 23'd0);
      nan2  = (e2 == 8'hFF) && (f2 != 23'd0);
      inf1  = (e1 == 8'hFF) && (f1 == 23'd0);
      inf2  = (e2 == 8'hFF) && (f2 == 23'd0);
      // exp=0 covers both zero and denormal: flushed to zero
      zero1 = (e1 == 8'd0);
      zero2 = (e2 == 8'd0);

      // A is the operand of larger magnitude
      swap    = in2[30:0] > in1[30:0];
      eff_sub = s1 ^ s2;
      sa      = swap ? s2 : s1;
      ea      = swap ? e2 : e1;
      eb      = swap ? e1 : e2;
      ma      = {1'b1, swap ? f2 : f1};
      mb      = {1'b1, swap ? f1 : f2};
      diff    = ea - eb;

      // three guard bits below the significand
      b_ext   = {mb, 3'b000};
      b_shift = b_ext >> diff;
      b_mask  = ~(27'h7FF_FFFF << diff);
      b_lost  = |(b_ext & b_mask);

      add_s = {1'b0, ma, 3'b000} + {1'b0, b_shift};
      // lost bits bump the subtrahend so the truncated difference
      // never exceeds the exact one (keeps round-toward-zero exact)
      sub_s = {ma, 3'b000} - (b_shift + {26'd0, b_lost});
      lz    = lzc27(sub_s);
      sub_n = sub_s << lz;

      if (eff_sub) begin
         exp_r  = $signed({2'b00, ea}) - $signed({5'd0, lz});
         mant_r = sub_n[25:3];
      end else if (add_s[27]) begin
         exp_r  = $signed({2'b00, ea}) + 10'sd1;
         mant_r = add_s[26:4];
      end else begin
         exp_r  = $signed({2'b00, ea});
         mant_r = add_s[25:3];
      end

      if (nan1 || nan2) begin
         result = QNAN;
      end else if (inf1 && inf2) begin
         result = (s1 != s2) ? QNAN : in1;
      end else if (inf1) begin
         result = in1;
      end else if (inf2) begin
         result = in2;
      end else if (zero1 && zero2) begin
         result = {s1 & s2, 31'd0};
      end else if (zero1) begin
         result = in2;
      end else if (zero2) begin
         result = in1;
      end else if (!eff_sub && !enable_add) begin
         result = 32'd0;
      end else if (eff_sub && !enable_sub) begin
         result = 32'd0;
      end else if (eff_sub && (sub_s == 27'd0)) begin
         result = 32'd0;
      end else if (exp_r >= 10'sd255) begin
         result = {sa, 8'hFF, 23'd0};
      end else if (exp_r <= 10'sd0) begin
         result = 32'd0;
      end else begin
         result = {sa, exp_r[7:0], mant_r};
      end

      sum_d       = in_valid ? result : sum_q;
      out_valid_d = in_valid;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         sum_q       <= 32'd0;
         out_valid_q <= 1'b0;
      end else begin
         sum_q       <= sum_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign sum       = sum_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_reflet_float_add_reg.sv
// tb_reflet_float_add_reg: self-checking bench for reflet_float_add_reg.
// Directed cases plus randomized operands against an exact-arithmetic model.
module tb_reflet_float_add_reg;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic [31:0] in1, in2;
   logic        enable_add, enable_sub;
   logic [31:0] sum;
   logic        out_valid;

   int n_checks = 0;
   int n_fail   = 0;

   reflet_float_add_reg dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in1        (in1),
      .in2        (in2),
      .enable_add (enable_add),
      .enable_sub (enable_sub),
      .sum        (sum),
      .out_valid  (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Exact model: each finite operand is an integer count of 2^-149 units,
   // summed exactly in a wide integer, then truncated to 24 bits.
   function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                           input logic en_a, input logic en_s);
      logic sa, sb, rs;
      logic [7:0] xa, xb;
      logic [22:0] fa, fb;
      logic [299:0] va, vb, mag, sh;
      int p, e;
      {sa, xa, fa} = a;
      {sb, xb, fb} = b;
      if ((xa == 8'hFF && fa != 0) || (xb == 8'hFF && fb != 0)) return 32'h7FC0_0000;
      if (xa == 8'hFF && xb == 8'hFF) return (sa != sb) ? 32'h7FC0_0000 : a;
      if (xa == 8'hFF) return a;
      if (xb == 8'hFF) return b;
      if (xa == 0 && xb == 0) return {sa & sb, 31'd0};
      if (xa == 0) return b;
      if (xb == 0) return a;
      if (sa == sb && !en_a) return 32'd0;
      if (sa != sb && !en_s) return 32'd0;
      va = 300'({1'b1, fa}) << (xa - 8'd1);
      vb = 300'({1'b1, fb}) << (xb - 8'd1);
      if (sa == sb) begin
         mag = va + vb; rs = sa;
      end else if (va > vb) begin
         mag = va - vb; rs = sa;
      end else if (vb > va) begin
         mag = vb - va; rs = sb;
      end else begin
         return 32'd0;
      end
      p = 0;
      for (int i = 0; i < 300; i++) if (mag[i]) p = i;
      e = p - 22;
      if (e >= 255) return {rs, 8'hFF, 23'd0};
      if (e <= 0) return 32'd0;
      sh = mag >> (p - 23);
      return {rs, 8'(e), sh[22:0]};
   endfunction

   function automatic logic [31:0] rnd_op(input int base);
      int k, ex;
      logic s;
      logic [22:0] m;
      k = $urandom_range(0, 19);
      s = 1'($urandom);
      m = 23'($urandom);
      if (k == 0) return {s, 8'd0, (k == 0 && s) ? m : 23'd0};
      if (k == 1) return {s, 8'hFF, 23'd0};
      if (k == 2) return {s, 8'hFF, m | 23'd1};
      if (k < 12) ex = base + $urandom_range(0, 6) - 3;
      else ex = $urandom_range(1, 254);
      if (ex < 1) ex = 1;
      if (ex > 254) ex = 254;
      if (k == 3) m = 23'h7FFFFF;
      return {s, 8'(ex), m};
   endfunction

   task automatic drive(input logic [31:0] a, input logic [31:0] b,
                        input logic ea, input logic es);
      in1 = a; in2 = b; enable_add = ea; enable_sub = es; in_valid = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      in_valid = 1'b1; in1 = 32'h40A0_0000; in2 = 32'h4170_0000;
      enable_add = 1'b1; enable_sub = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (sum !== 32'd0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_hold: sum=%h valid=%b, want 00000000/0", sum, out_valid);
      end
      reset = 1'b1; in_valid = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (sum !== 32'd0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle: sum=%h valid=%b, want 00000000/0", sum, out_valid);
      end
   endtask

   task automatic test_basic();
      drive(32'h40A0_0000, 32'h4170_0000, 1'b1, 1'b1);
      n_checks++;
      if (sum !== 32'h41A0_0000 || out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL add_5_15: sum=%h valid=%b, want 41a00000/1", sum, out_valid);
      end
      in_valid = 1'b0; in1 = 32'h3F80_0000; in2 = 32'h3F80_0000;
      @(posedge clk); #1;
      n_checks++;
      if (sum !== 32'h41A0_0000 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_hold: sum=%h valid=%b, want 41a00000/0", sum, out_valid);
      end
   endtask

   task automatic test_signed();
      logic [31:0] a [3];
      logic [31:0] b [3];
      logic [31:0] x [3];
      a = '{32'h40A0_0000, 32'h3F80_0000, 32'h3F80_0000};
      b = '{32'hC170_0000, 32'hBF80_0000, 32'h3380_0000};
      x = '{32'hC120_0000, 32'h0000_0000, 32'h3F80_0000};
      for (int i = 0; i < 3; i++) begin
         drive(a[i], b[i], 1'b1, 1'b1);
         n_checks++;
         if (sum !== x[i]) begin
            n_fail++;
            $display("FAIL signed_%0d: sum=%h, want %h", i, sum, x[i]);
         end
      end
   endtask

   task automatic test_enables();
      logic [31:0] b [3];
      logic [1:0]  en [3];
      logic [31:0] x [3];
      b  = '{32'hC170_0000, 32'h4170_0000, 32'h4170_0000};
      en = '{2'b10, 2'b01, 2'b10};
      x  = '{32'h0, 32'h0, 32'h41A0_0000};
      for (int i = 0; i < 3; i++) begin
         drive(32'h40A0_0000, b[i], en[i][1], en[i][0]);
         n_checks++;
         if (sum !== x[i]) begin
            n_fail++;
            $display("FAIL enable_%0d: sum=%h, want %h", i, sum, x[i]);
         end
      end
   endtask

   task automatic test_specials();
      logic [31:0] a [5];
      logic [31:0] b [5];
      logic [31:0] x [5];
      a = '{32'h7F80_0000, 32'h7F7F_FFFF, 32'h7F80_0001, 32'h8000_0000, 32'hFF80_0000};
      b = '{32'hFF80_0000, 32'h7F7F_FFFF, 32'h3F80_0000, 32'h8000_0000, 32'h4170_0000};
      x = '{32'h7FC0_0000, 32'h7F80_0000, 32'h7FC0_0000, 32'h8000_0000, 32'hFF80_0000};
      for (int i = 0; i < 5; i++) begin
         drive(a[i], b[i], 1'b1, 1'b1);
         n_checks++;
         if (sum !== x[i]) begin
            n_fail++;
            $display("FAIL special_%0d: sum=%h, want %h", i, sum, x[i]);
         end
      end
      drive(32'h0000_0000, 32'h8000_0000, 1'b1, 1'b1);
      n_checks++;
      if (sum !== 32'h0) begin
         n_fail++;
         $display("FAIL pz_plus_nz: sum=%h, want 00000000", sum);
      end
   endtask

   task automatic test_random();
      logic [31:0] a, b, x;
      logic ea, es;
      int base;
      for (int i = 0; i < 400; i++) begin
         base = $urandom_range(1, 254);
         a = rnd_op(base);
         b = rnd_op(base);
         ea = ($urandom_range(0, 3) != 0);
         es = ($urandom_range(0, 3) != 0);
         x = ref_add(a, b, ea, es);
         drive(a, b, ea, es);
         n_checks++;
         if (sum !== x || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL random_%0d: %h+%h en=%b%b sum=%h valid=%b, want %h/1",
                     i, a, b, ea, es, sum, out_valid, x);
         end
      end
   endtask

   task automatic test_back_to_back();
      in1 = 32'h40A0_0000; in2 = 32'h4170_0000;
      enable_add = 1'b1; enable_sub = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (sum !== 32'h41A0_0000 || out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_first: sum=%h valid=%b, want 41a00000/1", sum, out_valid);
      end
      in2 = 32'hC170_0000;
      @(posedge clk); #1;
      n_checks++;
      if (sum !== 32'hC120_0000 || out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_second: sum=%h valid=%b, want c1200000/1", sum, out_valid);
      end
      in2 = 32'h4170_0000;
      reset = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (sum !== 32'h0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_inflight: sum=%h valid=%b, want 00000000/0", sum, out_valid);
      end
      reset = 1'b1; in_valid = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (sum !== 32'h0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset: sum=%h valid=%b, want 00000000/0", sum, out_valid);
      end
   endtask

   initial begin
      reset = 1'b0; in_valid = 1'b0; in1 = 32'd0; in2 = 32'd0;
      enable_add = 1'b0; enable_sub = 1'b0;
      test_reset();
      test_basic();
      test_signed();
      test_enables();
      test_specials();
      test_random();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
